// File: rtl/test_status_monitor_if.sv
// Status-monitor bus: control inputs, watched registers and verdict outputs.
//   master : drives enable/clear/watched values/retire, observes verdict and statistics
//   slave  : the monitor itself
interface test_status_monitor_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) ();
  logic              enable_i;
  logic              clear_i;
  logic [DATA_W-1:0] done_reg_i;
  logic [DATA_W-1:0] result_reg_i;
  logic              retire_i;
  logic [2:0]        state_o;
  logic              pass_o;
  logic              fail_o;
  logic              timeout_o;
  logic              stall_o;
  logic              finished_o;
  logic [DATA_W-1:0] result_o;
  logic [CNT_W-1:0]  cycle_cnt_o;
  logic [CNT_W-1:0]  retire_cnt_o;

  modport master (
    output enable_i, clear_i, done_reg_i, result_reg_i, retire_i,
    input  state_o, pass_o, fail_o, timeout_o, stall_o, finished_o,
           result_o, cycle_cnt_o, retire_cnt_o
  );

  modport slave (
    input  enable_i, clear_i, done_reg_i, result_reg_i, retire_i,
    output state_o, pass_o, fail_o, timeout_o, stall_o, finished_o,
           result_o, cycle_cnt_o, retire_cnt_o
  );
endinterface

// File: rtl/test_status_monitor.sv
// Test status monitor: watches a "done" and a "result" register of a running
// test program and reaches a sticky verdict (pass/fail/timeout/stall).
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - slave side of test_status_monitor_if (enable/clear, watched
//            registers, retire pulse in; state, verdict flags, captured
//            result and cycle/retire statistics out, all registered)
module test_status_monitor #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DONE_VAL       = 1,
  parameter int unsigned PASS_VAL       = 1,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned STALL_CYCLES   = 4096
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  test_status_monitor_if.slave bus
);

  localparam int unsigned HOLD_W = 4;
  localparam bit          STALL_EN = (STALL_CYCLES != 0);
  localparam logic [DATA_W-1:0] DONE_MATCH = DATA_W'(DONE_VAL);
  localparam logic [DATA_W-1:0] PASS_MATCH = DATA_W'(PASS_VAL);
  localparam logic [CNT_W-1:0]  TIMEOUT_AT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STALL_AT   = CNT_W'(STALL_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_AT    = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    QUAL    = 3'd2,
    PASS    = 3'd3,
    FAIL    = 3'd4,
    TIMEOUT = 3'd5,
    STALL   = 3'd6
  } state_e;

  state_e            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next, hold_inc;
  logic [CNT_W-1:0]  cycle_cnt, cycle_next;
  logic [CNT_W-1:0]  retire_cnt, retire_next;
  logic [CNT_W-1:0]  stall_cnt, stall_next, stall_inc;
  logic [DATA_W-1:0] result, result_next;
  logic              done_hit;
  logic              pass_q, fail_q, timeout_q, stall_q, finished_q;

  // State and statistics registers; verdict flags are registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
      result     <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      stall_q    <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_next;
      cycle_cnt  <= cycle_next;
      retire_cnt <= retire_next;
      stall_cnt  <= stall_next;
      result     <= result_next;
      pass_q     <= (state_next == PASS);
      fail_q     <= (state_next == FAIL);
      timeout_q  <= (state_next == TIMEOUT);
      stall_q    <= (state_next == STALL);
      finished_q <= (state_next == PASS) || (state_next == FAIL) ||
                    (state_next == TIMEOUT) || (state_next == STALL);
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    cycle_next  = cycle_cnt;
    retire_next = retire_cnt;
    stall_next  = stall_cnt;
    result_next = result;
    done_hit    = (bus.done_reg_i == DONE_MATCH);
    // hold_cnt is always zero in RUN, so one increment covers both RUN and QUAL
    hold_inc    = hold_cnt + HOLD_W'(1);
    stall_inc   = stall_cnt + CNT_W'(1);

    if (bus.clear_i) begin
      state_next  = IDLE;
      hold_next   = '0;
      cycle_next  = '0;
      retire_next = '0;
      stall_next  = '0;
      result_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.enable_i) begin
            state_next  = RUN;
            hold_next   = '0;
            cycle_next  = '0;
            retire_next = '0;
            stall_next  = '0;
          end
        end
        RUN, QUAL: begin
          cycle_next = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
          if (bus.retire_i) begin
            retire_next = (retire_cnt == '1) ? retire_cnt : retire_cnt + CNT_W'(1);
            stall_next  = '0;
          end else begin
            stall_next  = stall_inc;
          end

          if (done_hit) begin
            state_next = QUAL;
            hold_next  = hold_inc;
          end else begin
            state_next = RUN;
            hold_next  = '0;
          end

          // Lowest priority first so later assignments win: stall < timeout < verdict.
          if (STALL_EN && !bus.retire_i && (stall_inc == STALL_AT)) begin
            state_next = STALL;
          end
          if (cycle_cnt == TIMEOUT_AT) begin
            state_next = TIMEOUT;
          end
          if (done_hit && (hold_inc == HOLD_AT)) begin
            state_next  = (bus.result_reg_i == PASS_MATCH) ? PASS : FAIL;
            result_next = bus.result_reg_i;
          end
        end
        PASS, FAIL, TIMEOUT, STALL: begin
          state_next = state;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.state_o      = state;
  assign bus.pass_o       = pass_q;
  assign bus.fail_o       = fail_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.stall_o      = stall_q;
  assign bus.finished_o   = finished_q;
  assign bus.result_o     = result;
  assign bus.cycle_cnt_o  = cycle_cnt;
  assign bus.retire_cnt_o = retire_cnt;

endmodule

// File: doc/test_status_monitor.md
TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of watched register values.
REQ-002 SHALL have parameter CNT_W, default 32, width of cycle and retire counters.
REQ-003 SHALL have parameter DONE_VAL, default 1, value of done_reg_i that signals end of test.
REQ-004 SHALL have parameter PASS_VAL, default 1, value of result_reg_i that signals pass.
REQ-005 SHALL have parameter HOLD_CYCLES, default 2 (range 1..15), consecutive cycles done_reg_i must equal DONE_VAL before a verdict is taken.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000000 (must be >= 1), maximum run length in cycles.
REQ-007 SHALL have parameter STALL_CYCLES, default 4096 (0 disables), maximum cycles without a retire pulse.
REQ-008 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port enable_i, input, 1, starts monitoring when high in IDLE.
REQ-011 SHALL have port clear_i, input, 1, synchronous return to IDLE from any state.
REQ-012 SHALL have port done_reg_i, input, DATA_W, watched "test done" register value (e.g. x26).
REQ-013 SHALL have port result_reg_i, input, DATA_W, watched "test result" register value (e.g. x27).
REQ-014 SHALL have port retire_i, input, 1, one-cycle pulse per retired instruction.
REQ-015 SHALL have port state_o, output, 3, current FSM state encoding.
REQ-016 SHALL have ports pass_o, fail_o, timeout_o, stall_o, output, 1 each, sticky verdict flags.
REQ-017 SHALL have port finished_o, output, 1, high in any terminal state.
REQ-018 SHALL have port result_o, output, DATA_W, result_reg_i captured at verdict.
REQ-019 SHALL have ports cycle_cnt_o and retire_cnt_o, output, CNT_W each, run statistics.

Function
REQ-020 SHALL implement states IDLE=0, RUN=1, QUAL=2, PASS=3, FAIL=4, TIMEOUT=5, STALL=6.
REQ-021 IDLE -> RUN SHALL occur on the cycle after enable_i is sampled high; the cycle, retire and stall counters SHALL be zeroed on that transition.
REQ-022 In RUN, done_reg_i==DONE_VAL SHALL move to QUAL with the hold counter set to 1; if HOLD_CYCLES==1 the verdict SHALL be taken on that same cycle instead.
REQ-023 In QUAL, each cycle with done_reg_i==DONE_VAL SHALL increment the hold counter; done_reg_i!=DONE_VAL SHALL return to RUN and zero the hold counter.
REQ-024 When the hold counter reaches HOLD_CYCLES, the next state SHALL be PASS if result_reg_i==PASS_VAL, else FAIL, and result_o SHALL capture result_reg_i on that edge.
REQ-025 cycle_cnt_o SHALL increment by 1 every cycle in RUN or QUAL and saturate at all-ones.
REQ-026 retire_cnt_o SHALL increment on each retire_i pulse in RUN or QUAL and saturate at all-ones.
REQ-027 Timeout SHALL fire when cycle_cnt_o == TIMEOUT_CYCLES-1 in RUN or QUAL, and the next state SHALL be TIMEOUT.
REQ-028 The stall counter SHALL reset on retire_i and otherwise increment in RUN or QUAL; reaching STALL_CYCLES SHALL move to STALL; STALL_CYCLES==0 SHALL disable stall detection.
REQ-029 Priority on the same cycle SHALL be verdict (REQ-024) > timeout > stall.
REQ-030 Terminal states SHALL hold, with counters frozen, until clear_i is asserted or reset occurs; enable_i SHALL be ignored in them.
REQ-031 clear_i SHALL have priority over all other transitions and SHALL force IDLE and zero all counters, flags and result_o on the next edge.
REQ-032 pass_o, fail_o, timeout_o and stall_o SHALL be high exactly when the state is PASS, FAIL, TIMEOUT or STALL respectively, and at most one SHALL be high at a time.
REQ-033 finished_o SHALL equal the OR of the four verdict flags.
REQ-034 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-035 Asserting rst_ni low SHALL immediately force IDLE and clear all outputs, counters and result_o to 0, regardless of clk_i and including mid-run or mid-QUAL.
REQ-036 After rst_ni deasserts, no transition SHALL occur until enable_i is sampled high.

Verification
REQ-037 Pass case: enable, after 50 cycles drive done=1 and result=1 for 2 cycles -> PASS, pass_o=1, result_o=1, cycle_cnt_o frozen.
REQ-038 Fail case: done=1, result=0x2A held 2 cycles -> FAIL, fail_o=1, result_o=0x2A.
REQ-039 Glitch case: done=1 for 1 cycle, then 0 -> QUAL, then back to RUN, no verdict; a later 2-cycle hold yields a verdict.
REQ-040 Timeout case: TIMEOUT_CYCLES=100, no done -> timeout_o rises after 100 RUN/QUAL cycles; verdict coinciding with the timeout cycle -> PASS/FAIL wins.
REQ-041 Stall case: STALL_CYCLES=16, retire_i pulses every 4 cycles, then stops -> STALL exactly 16 cycles after the last pulse, with retire_cnt_o correct.
REQ-042 Reset and clear case: rst_ni low during QUAL -> all outputs 0 asynchronously; clear_i in PASS -> IDLE on the next edge, and a new enable starts counts from 0.
